// File: rtl/wb_mux_n.sv
// Wishbone 1-to-N address decoder / multiplexer.
// A single master transaction is routed to the lowest-indexed slave whose
// masked base address matches. The transaction is latched and held for the
// slave, guarded by a response timeout, and then terminated towards the
// master with a one-cycle registered ack or err.
module wb_mux_n #(
  parameter int                      NSLAVES    = 4,
  parameter logic [NSLAVES*32-1:0]   SLAVE_MASK = '0,
  parameter logic [NSLAVES*32-1:0]   SLAVE_ADDR = '1,
  parameter int                      TIMEOUT    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [31:0]             wbm_adr_i,
  input  logic [31:0]             wbm_dat_i,
  input  logic [3:0]              wbm_sel_i,
  input  logic                    wbm_we_i,
  input  logic                    wbm_cyc_i,
  input  logic                    wbm_stb_i,
  output logic [31:0]             wbm_dat_o,
  output logic                    wbm_ack_o,
  output logic                    wbm_err_o,
  output logic [31:0]             wbs_adr_o,
  output logic [31:0]             wbs_dat_o,
  output logic [3:0]              wbs_sel_o,
  output logic                    wbs_we_o,
  output logic [NSLAVES-1:0]      wbs_cyc_o,
  output logic [NSLAVES-1:0]      wbs_stb_o,
  input  logic [NSLAVES*32-1:0]   wbs_dat_i,
  input  logic [NSLAVES-1:0]      wbs_ack_i,
  input  logic [NSLAVES-1:0]      wbs_err_i
);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  // Counter value seen in the last permitted ACTIVE cycle: ACTIVE lasts at
  // most TIMEOUT cycles before the access is failed with err.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t              state_reg, state_next;
  logic [NSLAVES-1:0]  grant_reg, grant_next;
  logic [31:0]         adr_reg, adr_next;
  logic [31:0]         wdat_reg, wdat_next;
  logic [3:0]          sel_reg, sel_next;
  logic                we_reg, we_next;
  logic [15:0]         cnt_reg, cnt_next;
  logic [31:0]         rdat_reg, rdat_next;
  logic                ack_reg, ack_next;
  logic                err_reg, err_next;

  logic [NSLAVES-1:0]  hit;
  logic [NSLAVES-1:0]  first_hit;
  logic [31:0]         rd_mux;
  logic                slv_ack;
  logic                slv_err;

  // Per-slave address match; a zero mask disables the slave entirely.
  genvar gi;
  generate
    for (gi = 0; gi < NSLAVES; gi++) begin : g_dec
      localparam logic [31:0] MASK = SLAVE_MASK[32*gi +: 32];
      localparam logic [31:0] BASE = SLAVE_ADDR[32*gi +: 32];
      assign hit[gi] = (MASK != 32'd0) && ((wbm_adr_i & MASK) == (BASE & MASK));
    end
  endgenerate

  // Isolate the lowest set bit so overlapping windows favour the lower index.
  assign first_hit = hit & ((~hit) + NSLAVES'(1));

  // Only the granted slave's terminations are visible to the FSM.
  assign slv_ack = |(wbs_ack_i & grant_reg);
  assign slv_err = |(wbs_err_i & grant_reg);

  // AND-OR read data select using the one-hot grant.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NSLAVES; k++) begin
      if (grant_reg[k]) rd_mux = rd_mux | wbs_dat_i[32*k +: 32];
    end
  end

  // Next-state and datapath decisions for the IDLE/ACTIVE/RESP sequence.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    adr_next   = adr_reg;
    wdat_next  = wdat_reg;
    sel_next   = sel_reg;
    we_next    = we_reg;
    cnt_next   = cnt_reg;
    rdat_next  = rdat_reg;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          if (|hit) begin
            state_next = ACTIVE;
            grant_next = first_hit;
            adr_next   = wbm_adr_i;
            wdat_next  = wbm_dat_i;
            sel_next   = wbm_sel_i;
            we_next    = wbm_we_i;
            cnt_next   = '0;
          end else begin
            // Decode error: nobody is strobed, master gets err directly.
            state_next = RESP;
            err_next   = 1'b1;
          end
        end
      end
      ACTIVE: begin
        cnt_next = cnt_reg + 16'd1;
        if (!wbm_cyc_i) begin
          // Master gave up; silently abandon the access.
          state_next = IDLE;
        end else if (slv_err) begin
          state_next = RESP;
          err_next   = 1'b1;
        end else if (slv_ack) begin
          state_next = RESP;
          ack_next   = 1'b1;
          if (!we_reg) rdat_next = rd_mux;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = RESP;
          err_next   = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      adr_reg   <= '0;
      wdat_reg  <= '0;
      sel_reg   <= '0;
      we_reg    <= 1'b0;
      cnt_reg   <= '0;
      rdat_reg  <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      adr_reg   <= adr_next;
      wdat_reg  <= wdat_next;
      sel_reg   <= sel_next;
      we_reg    <= we_next;
      cnt_reg   <= cnt_next;
      rdat_reg  <= rdat_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
    end
  end

  assign wbm_dat_o = rdat_reg;
  assign wbm_ack_o = ack_reg;
  assign wbm_err_o = err_reg;
  assign wbs_adr_o = adr_reg;
  assign wbs_dat_o = wdat_reg;
  assign wbs_sel_o = sel_reg;
  assign wbs_we_o  = we_reg;
  // Slave cyc/stb follow the grant only while the access is outstanding.
  assign wbs_cyc_o = (state_reg == ACTIVE) ? grant_reg : '0;
  assign wbs_stb_o = (state_reg == ACTIVE) ? grant_reg : '0;

endmodule

// File: tb/tb_wb_mux_n.sv
// Self-checking bench for wb_mux_n: directed scenarios followed by random
// transactions, each predicted by a transaction-level model of the decoder.
module tb_wb_mux_n;

  localparam int NS      = 4;
  localparam int TIMEOUT = 8;
  // slave3 (disabled) .. slave0
  localparam logic [NS*32-1:0] MASKS = {32'h0000_0000, 32'hFFFF_FF00, 32'hFFFF_F000, 32'hFFFF_F000};
  localparam logic [NS*32-1:0] ADDRS = {32'h0000_3000, 32'h0000_1000, 32'h0000_2000, 32'h0000_1000};

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [31:0]       wbm_adr_i, wbm_dat_i;
  logic [3:0]        wbm_sel_i;
  logic              wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [31:0]       wbm_dat_o;
  logic              wbm_ack_o, wbm_err_o;
  logic [31:0]       wbs_adr_o, wbs_dat_o;
  logic [3:0]        wbs_sel_o;
  logic              wbs_we_o;
  logic [NS-1:0]     wbs_cyc_o, wbs_stb_o;
  logic [NS*32-1:0]  wbs_dat_i;
  logic [NS-1:0]     wbs_ack_i, wbs_err_i;

  // Reference address map, written out per slave.
  logic [31:0] m_mask [NS] = '{32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FF00, 32'h0000_0000};
  logic [31:0] m_base [NS] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_1000, 32'h0000_3000};

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] last_read = 32'h0;

  wb_mux_n #(
    .NSLAVES(NS), .SLAVE_MASK(MASKS), .SLAVE_ADDR(ADDRS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Lowest-index slave whose masked window contains adr, or -1.
  function automatic int model_decode(input logic [31:0] adr);
    for (int k = 0; k < NS; k++) begin
      if (m_mask[k] != 0 && (adr & m_mask[k]) == (m_base[k] & m_mask[k])) return k;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic master_idle();
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_we_i = 1'b0;
    wbm_adr_i = '0;   wbm_dat_i = '0;   wbm_sel_i = '0;
  endtask

  task automatic slaves_quiet();
    wbs_ack_i = '0; wbs_err_i = '0; wbs_dat_i = '0;
  endtask

  task automatic master_drive(input logic [31:0] adr, input logic we, input logic [31:0] wd, input logic [3:0] sel);
    wbm_adr_i = adr; wbm_dat_i = wd; wbm_sel_i = sel; wbm_we_i = we;
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
  endtask

  task automatic random_slave_noise(input logic [3:0] g, input logic [3:0] noise_or);
    wbs_ack_i = (4'($urandom) | noise_or) & ~g;
    wbs_err_i = 4'($urandom) & ~g;
    wbs_dat_i = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "/stb"}, 32'(wbs_stb_o), 32'h0);
    chk({tag, "/cyc"}, 32'(wbs_cyc_o), 32'h0);
    chk({tag, "/ack"}, 32'(wbm_ack_o), 32'h0);
    chk({tag, "/err"}, 32'(wbm_err_o), 32'h0);
    chk({tag, "/mdat"}, wbm_dat_o, 32'h0);
    chk({tag, "/sadr"}, wbs_adr_o, 32'h0);
    chk({tag, "/sdat"}, wbs_dat_o, 32'h0);
    chk({tag, "/ssel"}, 32'(wbs_sel_o), 32'h0);
    chk({tag, "/swe"}, 32'(wbs_we_o), 32'h0);
  endtask

  // kind: 0 ack, 1 err, 2 no response, 3 ack+err together.
  // delay: ACTIVE cycles the slave waits before responding.
  task automatic run_txn(input string tag, input logic [31:0] adr, input logic we,
                         input logic [31:0] wd, input logic [3:0] sel, input int kind,
                         input int delay, input logic [31:0] rd, input logic [3:0] noise_or);
    int s, n_act;
    logic responded, term_err;
    logic [3:0] g;
    s = model_decode(adr);
    master_drive(adr, we, wd, sel);
    tick();
    if (s < 0) begin
      chk({tag, "/dec_stb"}, 32'(wbs_stb_o), 32'h0);
      chk({tag, "/dec_cyc"}, 32'(wbs_cyc_o), 32'h0);
      chk({tag, "/dec_err"}, 32'(wbm_err_o), 32'h1);
      chk({tag, "/dec_ack"}, 32'(wbm_ack_o), 32'h0);
      chk({tag, "/dec_dat"}, wbm_dat_o, last_read);
      master_idle();
      tick();
      chk({tag, "/dec_err_end"}, 32'(wbm_err_o), 32'h0);
      chk({tag, "/dec_stb_end"}, 32'(wbs_stb_o), 32'h0);
      $display("txn %s adr=%h we=%0d -> decode error", tag, adr, we);
      return;
    end
    g = 4'(1 << s);
    responded = (kind != 2) && (delay < TIMEOUT);
    n_act     = responded ? delay + 1 : TIMEOUT;
    term_err  = !responded || (kind != 0);
    for (int c = 0; c < n_act; c++) begin
      chk({tag, "/stb"}, 32'(wbs_stb_o), 32'(g));
      chk({tag, "/cyc"}, 32'(wbs_cyc_o), 32'(g));
      chk({tag, "/sadr"}, wbs_adr_o, adr);
      chk({tag, "/sdat"}, wbs_dat_o, wd);
      chk({tag, "/ssel"}, 32'(wbs_sel_o), 32'(sel));
      chk({tag, "/swe"}, 32'(wbs_we_o), 32'(we));
      chk({tag, "/early_term"}, 32'({wbm_ack_o, wbm_err_o}), 32'h0);
      random_slave_noise(g, noise_or);
      if (responded && c == n_act - 1) begin
        wbs_dat_i[32*s +: 32] = rd;
        if (kind == 0 || kind == 3) wbs_ack_i[s] = 1'b1;
        if (kind == 1 || kind == 3) wbs_err_i[s] = 1'b1;
      end
      tick();
    end
    slaves_quiet();
    if (!term_err && !we) last_read = rd;
    chk({tag, "/resp_stb"}, 32'(wbs_stb_o), 32'h0);
    chk({tag, "/resp_cyc"}, 32'(wbs_cyc_o), 32'h0);
    chk({tag, "/resp_ack"}, 32'(wbm_ack_o), 32'(!term_err));
    chk({tag, "/resp_err"}, 32'(wbm_err_o), 32'(term_err));
    chk({tag, "/resp_dat"}, wbm_dat_o, last_read);
    master_idle();
    tick();
    chk({tag, "/end_term"}, 32'({wbm_ack_o, wbm_err_o}), 32'h0);
    chk({tag, "/end_dat"}, wbm_dat_o, last_read);
    $display("txn %s adr=%h we=%0d slave=%0d kind=%0d delay=%0d -> %s dat=%h",
             tag, adr, we, s, kind, delay, term_err ? "err" : "ack", last_read);
  endtask

  // Master drops cyc after ncyc ACTIVE cycles while the slave acks at that edge.
  task automatic run_abort(input string tag, input logic [31:0] adr, input int ncyc);
    int s;
    logic [3:0] g;
    s = model_decode(adr);
    g = 4'(1 << s);
    master_drive(adr, 1'b0, 32'h0, 4'hF);
    tick();
    for (int c = 0; c <= ncyc; c++) begin
      chk({tag, "/stb"}, 32'(wbs_stb_o), 32'(g));
      random_slave_noise(g, 4'h0);
      if (c < ncyc) tick();
    end
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    wbs_ack_i = g;
    tick();
    slaves_quiet();
    chk({tag, "/abort_stb"}, 32'(wbs_stb_o), 32'h0);
    chk({tag, "/abort_cyc"}, 32'(wbs_cyc_o), 32'h0);
    chk({tag, "/abort_term"}, 32'({wbm_ack_o, wbm_err_o}), 32'h0);
    master_idle();
    tick();
    chk({tag, "/abort_term2"}, 32'({wbm_ack_o, wbm_err_o}), 32'h0);
    chk({tag, "/abort_dat"}, wbm_dat_o, last_read);
    $display("txn %s adr=%h aborted after %0d cycles", tag, adr, ncyc + 1);
  endtask

  // Reset pulsed in the second ACTIVE cycle, with a granted ack on the same edge.
  task automatic run_reset_mid(input string tag, input logic [31:0] adr);
    int s;
    logic [3:0] g;
    s = model_decode(adr);
    g = 4'(1 << s);
    master_drive(adr, 1'b1, 32'h1234_5678, 4'h3);
    tick();
    tick();
    chk({tag, "/pre_stb"}, 32'(wbs_stb_o), 32'(g));
    rst_i = 1'b1;
    wbs_ack_i = g;
    tick();
    rst_i = 1'b0;
    slaves_quiet();
    master_idle();
    last_read = 32'h0;
    check_all_zero(tag);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk({tag, "/post_term"}, 32'({wbm_ack_o, wbm_err_o}), 32'h0);
    end
    $display("txn %s adr=%h interrupted by reset", tag, adr);
  endtask

  initial begin
    int pick, kind, delay;
    logic [31:0] adr;

    rst_i = 1'b1;
    master_idle();
    slaves_quiet();
    tick();
    tick();
    check_all_zero("reset");
    rst_i = 1'b0;
    tick();
    check_all_zero("post_reset");

    run_txn("read_s1",      32'h0000_2004, 1'b0, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 4'h0);
    run_txn("unmapped_wr",  32'h8000_0000, 1'b1, 32'hCAFE_F00D, 4'hF, 0, 0, 32'h0, 4'h0);
    run_txn("timeout",      32'h0000_1204, 1'b0, 32'h0, 4'hF, 2, 0, 32'h0, 4'h0);
    run_txn("overlap",      32'h0000_1000, 1'b0, 32'h0, 4'hF, 0, 2, 32'h0BAD_F00D, 4'h4);
    run_txn("write_noupd",  32'h0000_2010, 1'b1, 32'h5555_AAAA, 4'h5, 0, 1, 32'h7777_7777, 4'h0);
    run_txn("slave_err",    32'h0000_10F0, 1'b0, 32'h0, 4'hF, 1, 3, 32'h1111_1111, 4'h0);
    run_txn("ack_and_err",  32'h0000_2FFC, 1'b0, 32'h0, 4'hF, 3, 0, 32'h2222_2222, 4'h0);
    run_txn("last_chance",  32'h0000_1800, 1'b0, 32'h0, 4'hF, 0, TIMEOUT - 1, 32'h3333_3333, 4'h0);
    run_txn("disabled_s3",  32'h0000_3004, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0, 4'h0);
    run_abort("abort",      32'h0000_2020, 2);
    run_txn("after_abort",  32'h0000_2024, 1'b0, 32'h0, 4'hF, 0, 0, 32'h4444_4444, 4'h0);
    run_reset_mid("rst_mid", 32'h0000_2030);
    run_txn("after_reset",  32'h0000_2034, 1'b0, 32'h0, 4'hF, 0, 1, 32'h9999_0001, 4'h0);

    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 4);
      case (pick)
        0:       adr = 32'h0000_1000 | ($urandom & 32'hFFF);
        1:       adr = 32'h0000_2000 | ($urandom & 32'hFFF);
        2:       adr = 32'h0000_3000 | ($urandom & 32'hFFF);
        3:       adr = $urandom | 32'h8000_0000;
        default: adr = 32'h0000_1000 | ($urandom & 32'hFF);
      endcase
      kind  = $urandom_range(0, 3);
      delay = $urandom_range(0, 9);
      run_txn($sformatf("rnd%0d", i), adr, 1'($urandom), $urandom, 4'($urandom),
              kind, delay, $urandom, 4'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_mux_n.md
WB_MUX_N -- requirements
Module: wb_mux_n

Interface
- REQ-001: Parameter NSLAVES, default 4: number of slave ports, legal 1..8.
- REQ-002: Parameter SLAVE_MASK, default all-zero (NSLAVES*32 bits): packed per-slave address masks, slave k at bits [32k+31:32k].
- REQ-003: Parameter SLAVE_ADDR, default all-ones (NSLAVES*32 bits): packed per-slave base addresses, same packing.
- REQ-004: Parameter TIMEOUT, default 255: slave response limit in cycles, legal 1..65535.
- REQ-005: clk_i  in  1  single clock; all state changes on its rising edge.
- REQ-006: rst_i  in  1  reset, synchronous, active-high.
- REQ-007: wbm_adr_i  in  32  master address.
- REQ-008: wbm_dat_i  in  32  master write data.
- REQ-009: wbm_sel_i  in  4  master byte selects.
- REQ-010: wbm_we_i, wbm_cyc_i, wbm_stb_i  in  1 each  master write enable, cycle, strobe.
- REQ-011: wbm_dat_o  out  32  registered read data to master.
- REQ-012: wbm_ack_o, wbm_err_o  out  1 each  registered termination to master.
- REQ-013: wbs_adr_o, wbs_dat_o  out  32 each  address/write data broadcast to all slaves.
- REQ-014: wbs_sel_o  out  4; wbs_we_o  out  1  broadcast selects and write enable.
- REQ-015: wbs_cyc_o, wbs_stb_o  out  NSLAVES each  one-hot per-slave cycle/strobe.
- REQ-016: wbs_dat_i  in  NSLAVES*32  packed per-slave read data.
- REQ-017: wbs_ack_i, wbs_err_i  in  NSLAVES each  per-slave terminations.

Function
- REQ-018: Slave k SHALL hit when (wbm_adr_i & mask_k) == (addr_k & mask_k) with mask_k nonzero; an all-zero mask SHALL disable slave k.
- REQ-019: Multiple hits SHALL resolve to the lowest index.
- REQ-020: FSM states IDLE, ACTIVE, RESP; reset state IDLE.
- REQ-021: IDLE: on edge sampling wbm_cyc_i&wbm_stb_i with a hit, latch one-hot grant, address, data, sel, we; go ACTIVE.
- REQ-022: IDLE: on cyc&stb with no hit, go RESP with err flag set; wbm_err_o high the cycle after that edge (decode error).
- REQ-023: ACTIVE: wbs_cyc_o/wbs_stb_o SHALL equal the grant; broadcast outputs SHALL hold latched values; all other slaves' cyc/stb low.
- REQ-024: ACTIVE: on edge sampling granted wbs_ack_i, capture granted wbs_dat_i into wbm_dat_o, go RESP with ack flag; slave cyc/stb low from that edge.
- REQ-025: ACTIVE: granted wbs_err_i SHALL go RESP with err flag; if ack and err both high, err wins; acks/errs from ungranted slaves SHALL be ignored.
- REQ-026: ACTIVE: 16-bit counter cleared on entry, incremented each cycle; on reaching TIMEOUT without termination, go RESP with err flag and drop slave cyc/stb.
- REQ-027: ACTIVE: if wbm_cyc_i sampled low, abort to IDLE, drop slave cyc/stb, no ack/err issued.
- REQ-028: RESP: exactly one of wbm_ack_o/wbm_err_o high for exactly one cycle, then IDLE unconditionally.
- REQ-029: Latency: slave ack sampled at edge N -> wbm_ack_o high in cycle after edge N; minimum 2 cycles from master strobe to ack.
- REQ-030: Back-to-back: a strobe still high in IDLE after RESP SHALL start a new transaction; no idle cycle is inserted beyond IDLE.
- REQ-031: wbm_dat_o SHALL hold its last captured value outside RESP; write transactions SHALL NOT update it.

Reset
- REQ-032: rst_i sampled high SHALL force IDLE, clear grant, counter, wbm_dat_o, wbm_ack_o, wbm_err_o, all wbs_cyc_o/wbs_stb_o, and broadcast outputs to 0, at any state including mid-transaction.
- REQ-033: No ack or err SHALL be issued for a transaction interrupted by reset.

Verification
- REQ-034: NSLAVES=4, slave1 mask 0xFFFFF000 addr 0x00002000; read 0x00002004, slave1 acks with 0xDEADBEEF one cycle after stb -> only wbs_stb_o[1] high, wbm_ack_o one cycle, wbm_dat_o=0xDEADBEEF.
- REQ-035: Write to unmapped 0x80000000 -> no wbs_stb_o asserted, wbm_err_o high one cycle after strobe sampled.
- REQ-036: TIMEOUT=8, mapped slave never responds -> slave stb dropped and wbm_err_o high exactly once after 8 ACTIVE cycles.
- REQ-037: Slaves 0 and 2 both match 0x1000 -> only slave 0 strobed; slave 2 ack injected concurrently is ignored.
- REQ-038: rst_i pulsed during ACTIVE -> next cycle all outputs 0, no ack/err ever issued for that access; following read completes normally.
- REQ-039: Master drops wbm_cyc_i in ACTIVE -> slave cyc/stb low next cycle, FSM IDLE, no termination to master.
